// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative unsigned multiply/divide unit for the execute stage.
//   Multiply (op_in=0): shift-add, {hi,lo} = a*b, full 2*DATA_WIDTH product.
//   Divide   (op_in=1): restoring, lo = quotient, hi = remainder.
//   Divide by zero finishes without iterating: lo = all ones, hi = dividend.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   en                clock enable; 0 freezes state, counter, datapath, outputs
//   start_in, op_in   request and operation select (sampled in IDLE/DONE)
//   cancel_in         abort while running (wins over a same-cycle start)
//   data_a_in         multiplicand / dividend
//   data_b_in         multiplier / divisor
//   busy_out          high while iterating
//   done_out          high in the DONE state (one enabled cycle)
//   lo_data_out       product low half / quotient
//   hi_data_out       product high half / remainder
//   div_by_zero_out   last completed op was a divide by zero
module mult_div_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start_in,
  input  logic                  cancel_in,
  input  logic                  op_in,
  input  logic [DATA_WIDTH-1:0] data_a_in,
  input  logic [DATA_WIDTH-1:0] data_b_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic [DATA_WIDTH-1:0] lo_data_out,
  output logic [DATA_WIDTH-1:0] hi_data_out,
  output logic                  div_by_zero_out
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic                    r_op;
  logic [DATA_WIDTH-1:0]   r_opnd;   // multiplicand (mul) or divisor (div)
  logic [2*DATA_WIDTH-1:0] r_acc;    // {partial hi, lo} (mul) / {remainder, quotient} (div)

  logic                    w_accept;
  logic                    w_zero_div;
  logic                    w_last;
  logic [DATA_WIDTH:0]     w_sum;
  logic [DATA_WIDTH:0]     w_shift;
  logic                    w_ge;
  logic [DATA_WIDTH-1:0]   w_sub;
  logic [2*DATA_WIDTH-1:0] w_step;

  // Next state and control strobes
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_zero_div = 1'b0;
    w_last     = 1'b0;
    if (en) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_in) begin
            w_accept = 1'b1;
            if (op_in && (data_b_in == '0)) begin
              w_zero_div = 1'b1;
              w_next     = S_DONE;
            end else begin
              w_next = S_RUN;
            end
          end else begin
            w_next = S_IDLE;
          end
        end
        S_RUN: begin
          if (cancel_in) begin
            w_next = S_IDLE;
          end else if (r_cnt == LAST_CNT) begin
            w_last = 1'b1;
            w_next = S_DONE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // One iteration of either algorithm on the shared accumulator.
  // Multiply adds the multiplicand into the upper half when the current
  // multiplier bit (acc[0]) is set, then shifts the whole thing right.
  // Divide shifts the next dividend bit into a DATA_WIDTH+1 bit trial
  // remainder; the difference fits DATA_WIDTH bits whenever it is kept.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_shift = r_acc[2*DATA_WIDTH-1:DATA_WIDTH-1];
    w_ge    = (w_shift >= {1'b0, r_opnd});
    w_sub   = w_shift[DATA_WIDTH-1:0] - r_opnd;
    if (!r_op) begin
      w_step = {w_sum, r_acc[DATA_WIDTH-1:1]};
    end else if (w_ge) begin
      w_step = {w_sub, r_acc[DATA_WIDTH-2:0], 1'b1};
    end else begin
      w_step = {w_shift[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else if (en) begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt           <= '0;
      r_op            <= 1'b0;
      r_opnd          <= '0;
      r_acc           <= '0;
      lo_data_out     <= '0;
      hi_data_out     <= '0;
      div_by_zero_out <= 1'b0;
    end else if (en) begin
      if (w_accept) begin
        r_op   <= op_in;
        r_opnd <= op_in ? data_b_in : data_a_in;
        r_acc  <= {{DATA_WIDTH{1'b0}}, (op_in ? data_a_in : data_b_in)};
        r_cnt  <= '0;
      end else if ((r_state == S_RUN) && !cancel_in) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_zero_div) begin
        lo_data_out     <= '1;
        hi_data_out     <= data_a_in;
        div_by_zero_out <= 1'b1;
      end else if (w_last) begin
        lo_data_out     <= w_step[DATA_WIDTH-1:0];
        hi_data_out     <= w_step[2*DATA_WIDTH-1:DATA_WIDTH];
        div_by_zero_out <= 1'b0;
      end
    end
  end

  assign busy_out = (r_state == S_RUN);
  assign done_out = (r_state == S_DONE);

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, en, start_in, cancel_in, op_in;
  logic [W-1:0] data_a_in, data_b_in;
  logic         busy_out, done_out, div_by_zero_out;
  logic [W-1:0] lo_data_out, hi_data_out;

  mult_div_unit #(.DATA_WIDTH(W), .CNT_WIDTH(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .start_in        (start_in),
    .cancel_in       (cancel_in),
    .op_in           (op_in),
    .data_a_in       (data_a_in),
    .data_b_in       (data_b_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .lo_data_out     (lo_data_out),
    .hi_data_out     (hi_data_out),
    .div_by_zero_out (div_by_zero_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference results of the last completed operation
  logic [W-1:0] m_lo, m_hi;
  logic         m_dbz;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_op(input bit op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] p;
    if (!op) begin
      p = {32'b0, a} * {32'b0, b};
      m_lo = p[31:0];
      m_hi = p[63:32];
      m_dbz = 1'b0;
    end else if (b == 0) begin
      m_lo = '1;
      m_hi = a;
      m_dbz = 1'b1;
    end else begin
      m_lo = a / b;
      m_hi = a % b;
      m_dbz = 1'b0;
    end
  endtask

  // Issue one operation at the current negedge and follow it to completion,
  // cancellation or reset. Cycle numbers count negedges after the start.
  task automatic do_op(input string tag, input bit op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int exp_cyc, input int stall_at,
                       input int stall_len, input int glitch_at, input int cancel_at,
                       input int rst_at, input bit rnd);
    int cyc, ecnt, busy_n, exp_lat;
    bit en_prev, fin;
    logic [W-1:0] old_lo, old_hi;
    old_lo  = m_lo;
    old_hi  = m_hi;
    exp_lat = (op && b == 0) ? 1 : W + 1;
    start_in  = 1'b1;
    op_in     = op;
    data_a_in = a;
    data_b_in = b;
    en        = 1'b1;
    cancel_in = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    en_prev = 1'b1;
    cyc = 0; ecnt = 0; busy_n = 0; fin = 1'b0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (en_prev) ecnt++;
      start_in  = 1'b0;
      cancel_in = 1'b0;
      if (cyc == cancel_at + 1) begin
        check({tag, "_cancel_busy"}, 64'(busy_out), 64'd0);
        check({tag, "_cancel_done"}, 64'(done_out), 64'd0);
        check({tag, "_cancel_lo"}, 64'(lo_data_out), 64'(old_lo));
        check({tag, "_cancel_hi"}, 64'(hi_data_out), 64'(old_hi));
        fin = 1'b1;
      end else if (done_out) begin
        model_op(op, a, b);
        check({tag, "_latency"}, 64'(ecnt), 64'(exp_lat));
        if (exp_cyc > 0) check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'(cyc - 1));
        check({tag, "_lo"}, 64'(lo_data_out), 64'(m_lo));
        check({tag, "_hi"}, 64'(hi_data_out), 64'(m_hi));
        check({tag, "_dbz"}, 64'(div_by_zero_out), 64'(m_dbz));
        fin = 1'b1;
      end else if (busy_out) begin
        busy_n++;
      end
      if (!fin) begin
        if (cyc == rst_at) begin
          rst = 1'b1;
          #1;
          check({tag, "_rst_busy"}, 64'(busy_out), 64'd0);
          check({tag, "_rst_done"}, 64'(done_out), 64'd0);
          check({tag, "_rst_lo"}, 64'(lo_data_out), 64'd0);
          check({tag, "_rst_hi"}, 64'(hi_data_out), 64'd0);
          check({tag, "_rst_dbz"}, 64'(div_by_zero_out), 64'd0);
          m_lo = '0; m_hi = '0; m_dbz = 1'b0;
          @(negedge clk);
          rst = 1'b0;
          en  = 1'b1;
          fin = 1'b1;
        end else begin
          if (cyc >= stall_at && cyc < stall_at + stall_len) en = 1'b0;
          else en = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
          if (cyc == glitch_at) begin
            start_in = 1'b1; op_in = 1'b0; data_a_in = 3; data_b_in = 3;
          end
          if (cyc == cancel_at) begin
            cancel_in = 1'b1; start_in = 1'b1; en = 1'b1;
          end
          en_prev = en;
        end
      end
    end
    if (!fin) check({tag, "_timeout"}, 64'd1, 64'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start_in = 1'b0; cancel_in = 1'b0; op_in = 1'b0;
    data_a_in = '0; data_b_in = '0;
    m_lo = '0; m_hi = '0; m_dbz = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy_out), 64'd0);
    check("reset_done", 64'(done_out), 64'd0);
    check("reset_lo", 64'(lo_data_out), 64'd0);
    check("reset_hi", 64'(hi_data_out), 64'd0);
    check("reset_dbz", 64'(div_by_zero_out), 64'd0);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);

    do_op("mul7x6", 1'b0, 7, 6, 33, -1, 0, -1, -1, -1, 1'b0);
    check("mul7x6_lo_const", 64'(lo_data_out), 64'd42);
    do_op("mulmax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, -1, 0, -1, -1, -1, 1'b0);
    check("mulmax_hi_const", 64'(hi_data_out), 64'hFFFF_FFFE);
    do_op("div100_7", 1'b1, 100, 7, 33, -1, 0, -1, -1, -1, 1'b0);
    check("div100_7_lo_const", 64'(lo_data_out), 64'd14);
    do_op("divmax_1", 1'b1, 32'hFFFF_FFFF, 1, 33, -1, 0, -1, -1, -1, 1'b0);

    // done_out holds while disabled in DONE
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("done_hold_en0", 64'(done_out), 64'd1);
    check("done_hold_lo", 64'(lo_data_out), 64'hFFFF_FFFF);
    en = 1'b1;

    do_op("div5_0", 1'b1, 5, 0, 1, -1, 0, -1, -1, -1, 1'b0);
    check("div5_0_hi_const", 64'(hi_data_out), 64'd5);
    do_op("div9_3", 1'b1, 9, 3, 33, -1, 0, -1, -1, -1, 1'b0);
    do_op("stall_glitch", 1'b0, 7, 6, 37, 15, 4, 10, -1, -1, 1'b0);
    do_op("cancel_div", 1'b1, 1000, 3, -1, -1, 0, -1, 5, -1, 1'b0);
    do_op("rst_mul", 1'b0, 12345, 678, -1, -1, 0, -1, -1, 12, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      bit rop;
      rop = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 4) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 2)) : W'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        start_in = 1'b0; cancel_in = 1'($urandom_range(0, 1)); en = 1'b1;
        @(negedge clk);
        cancel_in = 1'b0;
        check("rand_idle_done", 64'(done_out), 64'd0);
        check("rand_idle_lo", 64'(lo_data_out), 64'(m_lo));
      end
      do_op("rand", rop, ra, rb, -1, -1, 0, -1, -1, -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
